path_recorder: RTL and testbench

//  Run-length path recorder/replayer for the car. Records direction codes sampled on Tick as
//  (dir,count) runs in internal RAM, then replays them forward, or reversed with inverted

---
 rtl/path_pkg.sv | 38 +++
 rtl/path_ram.sv | 22 ++
 rtl/path_recorder.sv | 190 +++++++++++++++++++
 tb/tb_path_recorder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared direction/mode codes, recorder state encoding and the direction
// inversion used when replaying a path in reverse.
package path_pkg;

  localparam logic [7:0] DIR_STOP  = 8'd0;
  localparam logic [7:0] DIR_FWD   = 8'd1;
  localparam logic [7:0] DIR_BACK  = 8'd2;
  localparam logic [7:0] DIR_LEFT  = 8'd3;
  localparam logic [7:0] DIR_RIGHT = 8'd4;

  typedef enum logic [1:0] {
    MODE_IDLE       = 2'd0,
    MODE_RECORD     = 2'd1,
    MODE_REPLAY_FWD = 2'd2,
    MODE_REPLAY_REV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REC,
    S_FLUSH,
    S_RD_REQ,
    S_RD_WAIT,
    S_PLAY,
    S_FIN
  } state_e;

  function automatic logic [7:0] dir_invert(input logic [7:0] d);
    case (d)
      DIR_FWD:   return DIR_BACK;
      DIR_BACK:  return DIR_FWD;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/path_ram.sv
// Single-port synchronous RAM holding (dir,count) run entries; read data
// appears one clock after the address is presented.
module path_ram #(
  parameter  int DEPTH  = 1024,
  parameter  int WIDTH  = 17,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/path_recorder.sv
// Run-length path recorder/replayer: records Tick-sampled direction codes as
// (dir,count) runs and replays them forward or reversed with inverted dirs.
module path_recorder
  import path_pkg::*;
#(
  parameter  int DIR_W   = 3,
  parameter  int COUNT_W = 14,
  parameter  int DEPTH   = 1024,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Tick,
  input  logic [1:0]         Mode,
  input  logic               Start,
  input  logic               Stop,
  input  logic [DIR_W-1:0]   InDir,
  output logic [DIR_W-1:0]   OutDir,
  output logic               Busy,
  output logic               Done,
  output logic               Full,
  output logic [ADDR_W:0]    EntryCount,
  output logic [ADDR_W-1:0]  PlayIndex
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);
  localparam logic [ADDR_W:0]    ONE_A   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]  ONE_P   = ADDR_W'(1);
  localparam logic [ADDR_W:0]    DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [DIR_W-1:0]   STOP_C  = DIR_W'(DIR_STOP);

  state_e               r_state;
  logic [DIR_W-1:0]     r_run_dir;
  logic [COUNT_W-1:0]   r_run_cnt;
  logic                 r_run_valid;
  logic [COUNT_W-1:0]   r_remain;
  logic                 r_rev;
  logic                 r_done;
  logic                 r_full;
  logic [ADDR_W:0]      r_count;
  logic [ADDR_W-1:0]    r_pidx;
  logic [DIR_W-1:0]     r_outdir;

  logic                      w_full_cond;
  logic                      w_extend;
  logic                      w_rec_commit;
  logic                      w_flush_commit;
  logic                      w_we;
  logic                      w_last;
  logic [ADDR_W-1:0]         w_addr;
  logic [DIR_W+COUNT_W-1:0]  w_rdata;
  logic [DIR_W-1:0]          w_rd_dir;
  logic [COUNT_W-1:0]        w_rd_cnt;
  logic [DIR_W-1:0]          w_inv;

  assign w_full_cond    = (r_count == DEPTH_C);
  assign w_extend       = r_run_valid && (InDir == r_run_dir) && (r_run_cnt != CNT_MAX);
  assign w_rec_commit   = (r_state == S_REC) && Tick && r_run_valid && !w_extend;
  assign w_flush_commit = (r_state == S_FLUSH) && r_run_valid;
  assign w_we           = (w_rec_commit || w_flush_commit) && !w_full_cond;
  // Single port: writes only happen while recording, reads only while replaying.
  assign w_addr         = w_we ? r_count[ADDR_W-1:0] : r_pidx;
  assign w_rd_dir       = w_rdata[DIR_W+COUNT_W-1 -: DIR_W];
  assign w_rd_cnt       = w_rdata[COUNT_W-1:0];
  assign w_inv          = DIR_W'(dir_invert(8'(w_rd_dir)));
  assign w_last         = r_rev ? (r_pidx == '0) : ({1'b0, r_pidx} == (r_count - ONE_A));

  path_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DIR_W + COUNT_W)
  ) u_ram (
    .i_clk   (Clock),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata ({r_run_dir, r_run_cnt}),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_run_dir   <= '0;
      r_run_cnt   <= '0;
      r_run_valid <= 1'b0;
      r_remain    <= '0;
      r_rev       <= 1'b0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
      r_count     <= '0;
      r_pidx      <= '0;
      r_outdir    <= STOP_C;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (Mode == MODE_RECORD) begin
              r_state     <= S_REC;
              r_count     <= '0;
              r_full      <= 1'b0;
              r_run_valid <= 1'b0;
            end else if (Mode == MODE_REPLAY_FWD || Mode == MODE_REPLAY_REV) begin
              r_rev   <= (Mode == MODE_REPLAY_REV);
              r_pidx  <= (Mode == MODE_REPLAY_REV) ? ADDR_W'(r_count - ONE_A) : '0;
              r_state <= (r_count == '0) ? S_FIN : S_RD_REQ;
            end
          end
        end
        S_REC: begin
          if (Tick) begin
            if (!r_run_valid) begin
              r_run_dir   <= InDir;
              r_run_cnt   <= ONE_C;
              r_run_valid <= 1'b1;
            end else if (w_extend) begin
              r_run_cnt <= r_run_cnt + ONE_C;
            end else if (w_full_cond) begin
              r_full      <= 1'b1;
              r_run_valid <= 1'b0;
            end else begin
              r_count   <= r_count + ONE_A;
              r_run_dir <= InDir;
              r_run_cnt <= ONE_C;
            end
          end
          // A Full termination overrides a simultaneous Stop.
          if (w_rec_commit && w_full_cond) r_state <= S_FIN;
          else if (Stop)                   r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (r_run_valid) begin
            if (w_full_cond) r_full  <= 1'b1;
            else             r_count <= r_count + ONE_A;
          end
          r_run_valid <= 1'b0;
          r_state     <= S_FIN;
        end
        S_RD_REQ: begin
          if (Stop) begin
            r_outdir <= STOP_C;
            r_state  <= S_FIN;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (Stop) begin
            r_outdir <= STOP_C;
            r_state  <= S_FIN;
          end else begin
            r_remain <= w_rd_cnt;
            r_outdir <= r_rev ? w_inv : w_rd_dir;
            r_state  <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (Stop) begin
            r_outdir <= STOP_C;
            r_state  <= S_FIN;
          end else if (Tick) begin
            if (r_remain > ONE_C) begin
              r_remain <= r_remain - ONE_C;
            end else if (w_last) begin
              r_outdir <= STOP_C;
              r_state  <= S_FIN;
            end else begin
              r_pidx  <= r_rev ? (r_pidx - ONE_P) : (r_pidx + ONE_P);
              r_state <= S_RD_REQ;
            end
          end
        end
        S_FIN: begin
          r_done   <= 1'b1;
          r_outdir <= STOP_C;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign OutDir     = r_outdir;
  assign Busy       = (r_state != S_IDLE);
  assign Done       = r_done;
  assign Full       = r_full;
  assign EntryCount = r_count;
  assign PlayIndex  = r_pidx;

endmodule

// File: tb/tb_path_recorder.sv
// Scoreboard bench for path_recorder: a default-size instance plus a tiny
// COUNT_W=3/DEPTH=2 instance for saturation and Full behaviour.
module tb_path_recorder;
  import path_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset_n, Tick, Stop, Start1, Start2;
  logic [1:0] Mode;
  logic [2:0] InDir;

  logic [2:0]  od1, od2;
  logic        busy1, done1, full1, busy2, done2, full2;
  logic [10:0] ec1;
  logic [9:0]  pi1;
  logic [1:0]  ec2;
  logic [0:0]  pi2;

  path_recorder #(.DIR_W(3), .COUNT_W(14), .DEPTH(1024)) dut1 (
    .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .Mode(Mode), .Start(Start1),
    .Stop(Stop), .InDir(InDir), .OutDir(od1), .Busy(busy1), .Done(done1),
    .Full(full1), .EntryCount(ec1), .PlayIndex(pi1));

  path_recorder #(.DIR_W(3), .COUNT_W(3), .DEPTH(2)) dut2 (
    .Clock(Clock), .Reset_n(Reset_n), .Tick(Tick), .Mode(Mode), .Start(Start2),
    .Stop(Stop), .InDir(InDir), .OutDir(od2), .Busy(busy2), .Done(done2),
    .Full(full2), .EntryCount(ec2), .PlayIndex(pi2));

  typedef struct {
    int ec;
    int full;
    int od;
    int pidx;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   dq[$];
  int   rep_sel = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam int STOP_I  = int'(DIR_STOP);
  localparam int FWD_I   = int'(DIR_FWD);
  localparam int BACK_I  = int'(DIR_BACK);
  localparam int LEFT_I  = int'(DIR_LEFT);
  localparam int RIGHT_I = int'(DIR_RIGHT);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got output with empty scoreboard, expected none", name);
  endtask

  // Monitor: pops scoreboard entries on Done pulses and on replay Ticks.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (done1) begin
        if (q1.size() == 0) unexpected("done1");
        else begin
          e = q1.pop_front();
          check("done1_entrycount", int'(ec1), e.ec);
          check("done1_full", int'(full1), e.full);
          check("done1_outdir", int'(od1), e.od);
          check("done1_playindex", int'(pi1), e.pidx);
        end
      end
      if (done2) begin
        if (q2.size() == 0) unexpected("done2");
        else begin
          e = q2.pop_front();
          check("done2_entrycount", int'(ec2), e.ec);
          check("done2_full", int'(full2), e.full);
          check("done2_outdir", int'(od2), e.od);
          check("done2_playindex", int'(pi2), e.pidx);
        end
      end
      if (Tick && rep_sel != 0) begin
        if (dq.size() == 0) unexpected("replay_dir");
        else check("replay_dir", (rep_sel == 1) ? int'(od1) : int'(od2), dq.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic tick(input int d);
    @(posedge Clock); #1;
    InDir = 3'(d);
    Tick  = 1'b1;
    @(posedge Clock); #1;
    Tick = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int d, input int n);
    for (int i = 0; i < n; i++) tick(d);
  endtask

  task automatic pulse_start(input int which, input mode_e m);
    @(posedge Clock); #1;
    Mode = m;
    if (which == 1) Start1 = 1'b1;
    else            Start2 = 1'b1;
    @(posedge Clock); #1;
    Start1 = 1'b0;
    Start2 = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge Clock); #1;
    Stop = 1'b1;
    @(posedge Clock); #1;
    Stop = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    for (int i = 0; i < 200; i++) begin
      if (!((which == 1) ? busy1 : busy2)) break;
      @(posedge Clock); #1;
    end
    if ((which == 1) ? busy1 : busy2) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle%0d: got busy after 200 cycles, expected idle", which);
    end
    cyc(3);
  endtask

  task automatic push_dirs(input int d, input int n);
    for (int i = 0; i < n; i++) dq.push_back(d);
  endtask

  initial begin
    Reset_n = 1'b0; Tick = 1'b0; Stop = 1'b0; Start1 = 1'b0; Start2 = 1'b0;
    Mode = MODE_IDLE; InDir = '0;
    cyc(3);
    check("rst_outdir", int'(od1), STOP_I);
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_full", int'(full1), 0);
    check("rst_entrycount", int'(ec1), 0);
    check("rst_playindex", int'(pi1), 0);
    check("rst_entrycount2", int'(ec2), 0);
    Reset_n = 1'b1;
    cyc(2);

    // Record FWD x5, LEFT x3
    pulse_start(1, MODE_RECORD);
    check("rec_busy", int'(busy1), 1);
    ticks(FWD_I, 5);
    ticks(LEFT_I, 3);
    check("rec_entrycount_pending", int'(ec1), 1);
    q1.push_back('{2, 0, STOP_I, 0});
    pulse_stop();
    wait_idle(1);
    check("rec_entrycount", int'(ec1), 2);

    // Forward replay
    rep_sel = 1;
    push_dirs(FWD_I, 5);
    push_dirs(LEFT_I, 3);
    q1.push_back('{2, 0, STOP_I, 1});
    pulse_start(1, MODE_REPLAY_FWD);
    cyc(2);
    check("fwd_first_dir", int'(od1), FWD_I);
    ticks(STOP_I, 8);
    wait_idle(1);

    // Reverse replay
    push_dirs(RIGHT_I, 3);
    push_dirs(BACK_I, 5);
    q1.push_back('{2, 0, STOP_I, 0});
    pulse_start(1, MODE_REPLAY_REV);
    cyc(2);
    check("rev_start_index", int'(pi1), 1);
    check("rev_first_dir", int'(od1), RIGHT_I);
    ticks(STOP_I, 8);
    wait_idle(1);

    // Stop during replay after two Ticks
    push_dirs(FWD_I, 2);
    q1.push_back('{2, 0, STOP_I, 0});
    pulse_start(1, MODE_REPLAY_FWD);
    cyc(2);
    ticks(STOP_I, 2);
    pulse_stop();
    check("stop_abort_dir", int'(od1), STOP_I);
    wait_idle(1);
    rep_sel = 0;

    // Reset mid-record after one committed run
    pulse_start(1, MODE_RECORD);
    ticks(FWD_I, 2);
    ticks(LEFT_I, 1);
    check("midrec_entrycount", int'(ec1), 1);
    @(posedge Clock); #1;
    Reset_n = 1'b0;
    #1;
    check("midrst_outdir", int'(od1), STOP_I);
    check("midrst_entrycount", int'(ec1), 0);
    check("midrst_busy", int'(busy1), 0);
    cyc(2);
    Reset_n = 1'b1;
    cyc(2);

    // Replay with no entries
    q1.push_back('{0, 0, STOP_I, 0});
    pulse_start(1, MODE_REPLAY_FWD);
    check("empty_busy", int'(busy1), 1);
    check("empty_done_early", int'(done1), 0);
    cyc(1);
    check("empty_done", int'(done1), 1);
    check("empty_outdir", int'(od1), STOP_I);
    cyc(3);

    // Small instance: saturation split and Full on flush
    pulse_start(2, MODE_RECORD);
    ticks(FWD_I, 10);
    ticks(LEFT_I, 1);
    check("sat_entrycount", int'(ec2), 2);
    check("sat_full_before", int'(full2), 0);
    q2.push_back('{2, 1, STOP_I, 0});
    pulse_stop();
    wait_idle(2);
    check("sat_full", int'(full2), 1);

    rep_sel = 2;
    push_dirs(FWD_I, 10);
    q2.push_back('{2, 1, STOP_I, 1});
    pulse_start(2, MODE_REPLAY_FWD);
    cyc(2);
    ticks(STOP_I, 10);
    wait_idle(2);
    rep_sel = 0;

    check("scoreboard_drained", q1.size() + q2.size() + dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
